// File: rtl/prbs_lfsr_gen.sv
// Fibonacci LFSR PRBS generator with seed load, serial output and OUT_W-bit word port; PRBS_CHECKER_EN adds a lock/error checker.
// Latency: state advances one bit per enabled cycle; word_valid rises on the edge of the OUT_W-th step.
// Backpressure: the last bit of a word stalls while a previous word is still unconsumed (word_valid && !word_ready).
module prbs_lfsr_gen #(
  parameter int              WIDTH = 31,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(31'h4800_0000),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int              OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
`ifdef PRBS_CHECKER_EN
  input  logic             chk_in,
  input  logic             chk_valid,
  output logic             chk_locked,
  output logic [15:0]      err_cnt,
`endif
  output logic             ser_out,
  output logic [WIDTH-1:0] state_out,
  output logic [OUT_W-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             seed_err
);

  localparam int CNT_W = $clog2(OUT_W);

  logic [WIDTH-1:0] state;
  logic [OUT_W-2:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [OUT_W-1:0] sh_next;
  logic             fb;
  logic             cnt_last;
  logic             stall;
  logic             step;
  logic             seed_zero;

  assign fb        = ^(state & TAPS);
  assign ser_out   = state[WIDTH-1];
  assign state_out = state;
  assign sh_next   = {shreg, ser_out};
  assign cnt_last  = (bit_cnt == CNT_W'(OUT_W - 1));
  assign stall     = cnt_last && word_valid && !word_ready;
  assign step      = en && !load && !stall;
  assign seed_zero = (seed_in == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEED;
      shreg      <= '0;
      bit_cnt    <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      seed_err   <= 1'b0;
    end else if (load) begin
      // A zero seed would lock the LFSR, so substitute the reset seed.
      state      <= seed_zero ? SEED : seed_in;
      seed_err   <= seed_zero;
      shreg      <= '0;
      bit_cnt    <= '0;
      word_valid <= 1'b0;
    end else begin
      if (step) begin
        state <= {state[WIDTH-2:0], fb};
        shreg <= sh_next[OUT_W-2:0];
        if (cnt_last) begin
          word_out   <= sh_next;
          word_valid <= 1'b1;
          bit_cnt    <= '0;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
      if (!(step && cnt_last) && word_valid && word_ready)
        word_valid <= 1'b0;
    end
  end

`ifdef PRBS_CHECKER_EN
  localparam int MC_W = $clog2(WIDTH);

  logic [WIDTH-1:0] chk_reg;
  logic [MC_W-1:0]  match_cnt;
  logic [14:0]      miss_hist;
  logic [4:0]       miss_sum;
  logic             chk_pred;
  logic             chk_miss;

  assign chk_pred = ^(chk_reg & TAPS);
  assign chk_miss = chk_in ^ chk_pred;

  // Mismatches over the 16-bit window ending with the current bit.
  always_comb begin
    miss_sum = 5'(chk_miss);
    for (int i = 0; i < 15; i++)
      miss_sum = miss_sum + 5'(miss_hist[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_reg    <= '0;
      match_cnt  <= '0;
      miss_hist  <= '0;
      chk_locked <= 1'b0;
      err_cnt    <= '0;
    end else if (chk_valid) begin
      if (!chk_locked) begin
        chk_reg <= {chk_reg[WIDTH-2:0], chk_in};
        if (chk_miss) begin
          match_cnt <= '0;
        end else if (match_cnt == MC_W'(WIDTH - 1)) begin
          chk_locked <= 1'b1;
          match_cnt  <= '0;
          miss_hist  <= '0;
        end else begin
          match_cnt <= match_cnt + MC_W'(1);
        end
      end else begin
        chk_reg   <= {chk_reg[WIDTH-2:0], chk_pred};
        miss_hist <= {miss_hist[13:0], chk_miss};
        if (chk_miss && err_cnt != 16'hFFFF)
          err_cnt <= err_cnt + 16'd1;
        if (miss_sum >= 5'd8)
          chk_locked <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_prbs_lfsr_gen.sv
// Directed bench for prbs_lfsr_gen: a WIDTH=4 instance and a default-parameter instance.
module tb_prbs_lfsr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en, load, word_ready;
  logic [3:0]  seed_in;
  logic        s_ser, s_valid, s_err;
  logic [3:0]  s_state, s_word;

  logic        d_en, d_load, d_ready;
  logic [30:0] d_seed;
  logic        d_ser, d_valid, d_err;
  logic [30:0] d_state;
  logic [7:0]  d_word;

`ifdef PRBS_CHECKER_EN
  logic        chk_inv;
  logic        s_chk_in;
  logic        s_locked, d_locked;
  logic [15:0] s_errcnt, d_errcnt;
  logic        d_chk_in, d_chk_valid;
  assign s_chk_in = s_ser ^ chk_inv;
`endif

  prbs_lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .OUT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed_in(seed_in),
`ifdef PRBS_CHECKER_EN
    .chk_in(s_chk_in), .chk_valid(en), .chk_locked(s_locked), .err_cnt(s_errcnt),
`endif
    .ser_out(s_ser), .state_out(s_state), .word_out(s_word),
    .word_valid(s_valid), .word_ready(word_ready), .seed_err(s_err)
  );

  prbs_lfsr_gen u_dflt (
    .clk(clk), .rst_n(rst_n), .en(d_en), .load(d_load), .seed_in(d_seed),
`ifdef PRBS_CHECKER_EN
    .chk_in(d_chk_in), .chk_valid(d_chk_valid), .chk_locked(d_locked), .err_cnt(d_errcnt),
`endif
    .ser_out(d_ser), .state_out(d_state), .word_out(d_word),
    .word_valid(d_valid), .word_ready(d_ready), .seed_err(d_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] exp_st [0:14] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  logic [3:0] exp_w  [0:3]  = '{4'h1, 4'h3, 4'h5, 4'hE};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; seed_in = 4'h0; word_ready = 1'b1;
    d_en = 1'b0; d_load = 1'b0; d_seed = 31'h0; d_ready = 1'b1;
`ifdef PRBS_CHECKER_EN
    chk_inv = 1'b0; d_chk_in = 1'b0; d_chk_valid = 1'b0;
`endif
    #12;
    check("rst_state", 32'(s_state), 32'h1);
    check("rst_ser", 32'(s_ser), 32'h0);
    check("rst_word", 32'(s_word), 32'h0);
    check("rst_valid", 32'(s_valid), 32'h0);
    check("rst_seed_err", 32'(s_err), 32'h0);
    check("rst_dflt_state", 32'(d_state), 32'h1);

    // Free-running sequence and words
    rst_n = 1'b1;
    en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("seq_state", 32'(s_state), 32'(exp_st[k % 15]));
      if (k % 4 == 0) begin
        check("seq_valid", 32'(s_valid), 32'h1);
        check("seq_word", 32'(s_word), 32'(exp_w[k / 4 - 1]));
      end else if (k % 4 == 1 && k > 1) begin
        check("seq_valid_clr", 32'(s_valid), 32'h0);
      end
    end

    // Backpressure: stall on the last bit of the second word
    en = 1'b0;
    word_ready = 1'b0;
    do_reset();
    en = 1'b1;
    repeat (10) tick();
    check("bp_state_frozen", 32'(s_state), 32'hA);
    check("bp_valid", 32'(s_valid), 32'h1);
    check("bp_word_held", 32'(s_word), 32'h1);
    word_ready = 1'b1;
    tick();
    check("bp_word2", 32'(s_word), 32'h3);
    check("bp_valid2", 32'(s_valid), 32'h1);
    check("bp_state_resume", 32'(s_state), 32'h5);
    tick();
    check("bp_valid_clr", 32'(s_valid), 32'h0);
    check("bp_state_next", 32'(s_state), 32'hB);

    // Seed load mid-word, zero seed, en freeze
    en = 1'b0;
    do_reset();
    en = 1'b1;
    repeat (2) tick();
    load = 1'b1; seed_in = 4'h9;
    tick();
    load = 1'b0;
    check("ld_state", 32'(s_state), 32'h9);
    check("ld_valid", 32'(s_valid), 32'h0);
    check("ld_seed_err", 32'(s_err), 32'h0);
    repeat (4) tick();
    check("ld_state4", 32'(s_state), 32'hA);
    check("ld_word_valid", 32'(s_valid), 32'h1);
    check("ld_word", 32'(s_word), 32'h9);
    word_ready = 1'b0;
    load = 1'b1; seed_in = 4'h0;
    tick();
    check("ld0_state", 32'(s_state), 32'h1);
    check("ld0_seed_err", 32'(s_err), 32'h1);
    check("ld0_discard", 32'(s_valid), 32'h0);
    seed_in = 4'h5;
    tick();
    load = 1'b0; en = 1'b0;
    check("ld5_state", 32'(s_state), 32'h5);
    check("ld5_seed_err", 32'(s_err), 32'h0);
    repeat (2) tick();
    check("en0_freeze", 32'(s_state), 32'h5);

    // Default parameters: x^31+x^28+1
    word_ready = 1'b1;
    do_reset();
    d_en = 1'b1;
    check("dflt_ser0", 32'(d_ser), 32'h0);
    for (int k = 1; k <= 30; k++) begin
      tick();
      check("dflt_ser", 32'(d_ser), 32'(k == 30));
      if (k == 28) check("dflt_state28", 32'(d_state), 32'h1000_0001);
    end
    d_en = 1'b0;

    // Async reset pulsed between edges while a word is pending
    word_ready = 1'b0;
    do_reset();
    en = 1'b1;
    load = 1'b1; seed_in = 4'h0;
    tick();
    load = 1'b0;
    check("ar_seed_err_set", 32'(s_err), 32'h1);
    repeat (4) tick();
    check("ar_valid_set", 32'(s_valid), 32'h1);
    check("ar_word_set", 32'(s_word), 32'h1);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_state", 32'(s_state), 32'h1);
    check("ar_ser", 32'(s_ser), 32'h0);
    check("ar_word", 32'(s_word), 32'h0);
    check("ar_valid", 32'(s_valid), 32'h0);
    check("ar_seed_err", 32'(s_err), 32'h0);
    rst_n = 1'b1;

`ifdef PRBS_CHECKER_EN
    // Loopback checker: lock, then isolated bit errors
    tick();
    word_ready = 1'b1;
    chk_inv = 1'b0;
    do_reset();
    check("chk_rst_locked", 32'(s_locked), 32'h0);
    en = 1'b1;
    repeat (12) tick();
    check("chk_locked", 32'(s_locked), 32'h1);
    check("chk_err0", 32'(s_errcnt), 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk_inv = 1'b1;
      tick();
      chk_inv = 1'b0;
      repeat (5) tick();
    end
    check("chk_err3", 32'(s_errcnt), 32'h3);
    check("chk_lock_held", 32'(s_locked), 32'h1);
    en = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
